// File: rtl/id_claim_if.sv
// Handshake bundle between the ID claim controller, the random ID generator
// and the packet controller's outbound claim path.
interface id_claim_if #(
    parameter int ID_WIDTH  = 8,
    parameter int MAX_RETRY = 4
);
    localparam int RW = $clog2(MAX_RETRY + 1);

    logic                start;
    logic                rand_req;
    logic                rand_valid;
    logic [ID_WIDTH-1:0] rand_id;
    logic                claim_valid;
    logic [ID_WIDTH-1:0] claim_id;
    logic                claim_ready;
    logic                conflict;
    logic [ID_WIDTH-1:0] conflict_id;
    logic [ID_WIDTH-1:0] node_id;
    logic                id_valid;
    logic                busy;
    logic                fail;
    logic [RW-1:0]       retry_count;

    modport master (
        input  start, rand_valid, rand_id, claim_ready, conflict, conflict_id,
        output rand_req, claim_valid, claim_id, node_id, id_valid, busy, fail,
               retry_count
    );

    modport slave (
        output start, rand_valid, rand_id, claim_ready, conflict, conflict_id,
        input  rand_req, claim_valid, claim_id, node_id, id_valid, busy, fail,
               retry_count
    );
endinterface

// File: rtl/id_claim_controller.sv
// Claims a unique node ID: fetch a random candidate, broadcast it, listen for
// a matching foreign claim, then commit or retry within a bounded budget.
module id_claim_controller #(
    parameter int ID_WIDTH       = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_RETRY      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    id_claim_if.master bus
);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_RAND,
        S_SEND_CLAIM,
        S_LISTEN,
        S_DONE,
        S_FAIL
    } state_t;

    state_t              state;
    logic [TW-1:0]       timer;
    logic                rand_req;
    logic                claim_valid;
    logic [ID_WIDTH-1:0] claim_id;
    logic [ID_WIDTH-1:0] node_id;
    logic                id_valid;
    logic                busy;
    logic                fail;
    logic [RW-1:0]       retry_count;

    logic reserved;
    logic hit_candidate;
    logic hit_node;

    // 0 means unassigned and all-ones is the broadcast address; never claim them.
    assign reserved      = (bus.rand_id == '0) || (bus.rand_id == '1);
    assign hit_candidate = bus.conflict && (bus.conflict_id == claim_id);
    assign hit_node      = bus.conflict && (bus.conflict_id == node_id);

    // NOTE: state and outputs are flops, so every assignment here is
    // non-blocking; a blocking '=' would make later reads in the same block see
    // the new value and break the register semantics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            timer       <= '0;
            rand_req    <= 1'b0;
            claim_valid <= 1'b0;
            claim_id    <= '0;
            node_id     <= '0;
            id_valid    <= 1'b0;
            busy        <= 1'b0;
            fail        <= 1'b0;
            retry_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state       <= S_REQ_RAND;
                        rand_req    <= 1'b1;
                        busy        <= 1'b1;
                        retry_count <= '0;
                    end
                end

                // rand_req is high throughout this state, so rand_valid alone
                // completes the handshake; reserved values simply keep asking.
                S_REQ_RAND: begin
                    if (bus.rand_valid && !reserved) begin
                        state       <= S_SEND_CLAIM;
                        claim_id    <= bus.rand_id;
                        rand_req    <= 1'b0;
                        claim_valid <= 1'b1;
                    end
                end

                S_SEND_CLAIM: begin
                    if (bus.claim_ready) begin
                        state       <= S_LISTEN;
                        claim_valid <= 1'b0;
                        timer       <= '0;
                    end
                end

                // A collision wins over timer expiry in the same cycle.
                S_LISTEN: begin
                    if (hit_candidate) begin
                        retry_count <= retry_count + RW'(1);
                        if (retry_count == RETRY_LAST) begin
                            state <= S_FAIL;
                            fail  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= S_REQ_RAND;
                            rand_req <= 1'b1;
                        end
                    end else if (timer == TIMER_LAST) begin
                        state    <= S_DONE;
                        node_id  <= claim_id;
                        id_valid <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                S_DONE: begin
                    if (hit_node || bus.start) begin
                        state       <= S_REQ_RAND;
                        id_valid    <= 1'b0;
                        node_id     <= '0;
                        retry_count <= '0;
                        rand_req    <= 1'b1;
                        busy        <= 1'b1;
                    end
                end

                S_FAIL: begin
                    if (bus.start) begin
                        state       <= S_REQ_RAND;
                        fail        <= 1'b0;
                        retry_count <= '0;
                        rand_req    <= 1'b1;
                        busy        <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rand_req    = rand_req;
    assign bus.claim_valid = claim_valid;
    assign bus.claim_id    = claim_id;
    assign bus.node_id     = node_id;
    assign bus.id_valid    = id_valid;
    assign bus.busy        = busy;
    assign bus.fail        = fail;
    assign bus.retry_count = retry_count;
endmodule

// File: tb/tb_id_claim_controller.sv
// Bench for id_claim_controller: directed scenarios plus randomized claims,
// each checked against an attempt-level model of the claim protocol.
module tb_id_claim_controller;
    localparam int ID_WIDTH       = 8;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int MAX_RETRY      = 4;

    logic clk;
    logic rst_n;

    id_claim_if #(.ID_WIDTH(ID_WIDTH), .MAX_RETRY(MAX_RETRY)) bus ();

    id_claim_controller #(
        .ID_WIDTH      (ID_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MAX_RETRY     (MAX_RETRY)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run;
    int n_fail;

    // Scenario description: raw generator output, and per attempt the listen
    // timer value at which a matching claim arrives (-1 for none).
    logic [7:0] raw_ids[$];
    int         hit_at[$];
    int         decoy_at;
    bit         poke_start;

    // Model results.
    logic [7:0] exp_cands[$];
    int         exp_edges;
    bit         exp_fail;
    logic [7:0] exp_node;
    int         exp_retry;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit is_reserved(input logic [7:0] v);
        return (v == 8'h00) || (v == 8'hFF);
    endfunction

    // Attempt-level model. Edge count includes the edge that starts the claim:
    // one edge per generator handshake (discards included), one for the claim
    // handshake, then h+1 listen edges for a collision at timer h, or the full
    // listen window for a commit.
    task automatic model();
        int idx;
        int hit;
        exp_cands.delete();
        exp_edges = 1;
        exp_fail  = 1'b0;
        exp_node  = 8'h00;
        exp_retry = 0;
        idx       = 0;
        for (int k = 0; k < MAX_RETRY; k++) begin
            while (idx < raw_ids.size() && is_reserved(raw_ids[idx])) begin
                exp_edges++;
                idx++;
            end
            exp_cands.push_back(raw_ids[idx]);
            idx++;
            exp_edges += 2;
            hit = (k < hit_at.size()) ? hit_at[k] : -1;
            if (hit >= 0) begin
                exp_edges += hit + 1;
                exp_retry++;
                if (exp_retry == MAX_RETRY) begin
                    exp_fail = 1'b1;
                    break;
                end
            end else begin
                exp_edges += TIMEOUT_CYCLES;
                exp_node = raw_ids[idx-1];
                break;
            end
        end
    endtask

    // Runs one claim. With use_start=0 the claim was already kicked off by the
    // previous edge (e.g. a conflict on the committed ID).
    task automatic run_claim(input string name, input bit use_start);
        int edges;
        int k;
        int ptr;
        int listen_t;
        int guard;
        bit in_listen;
        bit was_rreq;
        bit was_claim;
        bit was_resv;
        model();
        if (use_start) begin
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
        end
        edges = 1;
        chk({name, ".rand_req_after_start"}, 32'(bus.rand_req), 32'd1);
        chk({name, ".busy_after_start"}, 32'(bus.busy), 32'd1);
        chk({name, ".fail_after_start"}, 32'(bus.fail), 32'd0);
        chk({name, ".id_valid_after_start"}, 32'(bus.id_valid), 32'd0);
        k = -1;
        ptr = 0;
        listen_t = 0;
        in_listen = 1'b0;
        guard = 0;
        while (!(bus.id_valid || bus.fail) && guard < 400) begin
            if (bus.claim_valid) begin
                k++;
                chk({name, ".claim_id"}, 32'(bus.claim_id), 32'(exp_cands[k]));
                chk({name, ".retry_at_claim"}, 32'(bus.retry_count), 32'(k));
            end
            bus.conflict    = 1'b0;
            bus.conflict_id = 8'h00;
            if (in_listen && k >= 0) begin
                if (k < hit_at.size() && hit_at[k] == listen_t) begin
                    bus.conflict    = 1'b1;
                    bus.conflict_id = exp_cands[k];
                end else if (decoy_at == listen_t) begin
                    bus.conflict    = 1'b1;
                    bus.conflict_id = ~exp_cands[k];
                end
            end
            bus.start   = poke_start && in_listen && listen_t == 3;
            bus.rand_id = (ptr < raw_ids.size()) ? raw_ids[ptr] : 8'h5A;
            was_rreq  = bus.rand_req;
            was_claim = bus.claim_valid;
            was_resv  = is_reserved(bus.rand_id);
            step();
            edges++;
            if (was_rreq) begin
                ptr++;
                if (was_resv) begin
                    chk({name, ".discard_keeps_req"}, 32'(bus.rand_req), 32'd1);
                    chk({name, ".discard_no_claim"}, 32'(bus.claim_valid), 32'd0);
                end
            end
            if (was_claim) begin
                in_listen = 1'b1;
                listen_t  = 0;
            end else if (in_listen) begin
                listen_t++;
            end
            if (bus.rand_req || bus.id_valid || bus.fail) in_listen = 1'b0;
            guard++;
        end
        bus.conflict = 1'b0;
        bus.start    = 1'b0;
        chk({name, ".latency_edges"}, 32'(edges), 32'(exp_edges));
        chk({name, ".fail"}, 32'(bus.fail), 32'(exp_fail));
        chk({name, ".id_valid"}, 32'(bus.id_valid), 32'(!exp_fail));
        chk({name, ".node_id"}, 32'(bus.node_id), 32'(exp_node));
        chk({name, ".retry_count"}, 32'(bus.retry_count), 32'(exp_retry));
        chk({name, ".busy_end"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic chk_reset_values(input string name);
        chk({name, ".rand_req"}, 32'(bus.rand_req), 32'd0);
        chk({name, ".claim_valid"}, 32'(bus.claim_valid), 32'd0);
        chk({name, ".claim_id"}, 32'(bus.claim_id), 32'd0);
        chk({name, ".node_id"}, 32'(bus.node_id), 32'd0);
        chk({name, ".id_valid"}, 32'(bus.id_valid), 32'd0);
        chk({name, ".busy"}, 32'(bus.busy), 32'd0);
        chk({name, ".fail"}, 32'(bus.fail), 32'd0);
        chk({name, ".retry_count"}, 32'(bus.retry_count), 32'd0);
    endtask

    initial begin
        int guard;
        n_run  = 0;
        n_fail = 0;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.rand_valid  = 1'b1;
        bus.rand_id     = 8'h00;
        bus.claim_ready = 1'b1;
        bus.conflict    = 1'b0;
        bus.conflict_id = 8'h00;
        decoy_at   = -1;
        poke_start = 1'b0;
        step();
        step();
        chk_reset_values("reset");
        rst_n = 1'b1;
        step();
        chk_reset_values("idle");

        // Best case: 19 edges counting the start edge itself.
        raw_ids = '{8'h3C};
        hit_at  = '{-1};
        run_claim("basic", 1'b1);

        raw_ids = '{8'h00, 8'hFF, 8'h21};
        hit_at  = '{-1};
        run_claim("discard", 1'b1);

        raw_ids = '{8'h5A, 8'h44};
        hit_at  = '{5, -1};
        run_claim("retry_t5", 1'b1);

        // Matching conflict on the committed ID re-opens the claim next edge.
        bus.conflict    = 1'b1;
        bus.conflict_id = 8'h44;
        step();
        bus.conflict = 1'b0;
        chk("done_conflict.id_valid", 32'(bus.id_valid), 32'd0);
        chk("done_conflict.node_id", 32'(bus.node_id), 32'd0);
        chk("done_conflict.retry", 32'(bus.retry_count), 32'd0);
        raw_ids = '{8'h77};
        hit_at  = '{-1};
        run_claim("reclaim", 1'b0);

        raw_ids = '{8'h11, 8'h22, 8'h33, 8'h44};
        hit_at  = '{2, 0, 7, 3};
        run_claim("exhaust", 1'b1);

        raw_ids = '{8'h66, 8'h78};
        hit_at  = '{TIMEOUT_CYCLES - 1, -1};
        run_claim("last_cycle_hit", 1'b1);

        raw_ids  = '{8'h88};
        hit_at   = '{-1};
        decoy_at = 8;
        run_claim("foreign_conflict", 1'b1);
        decoy_at = -1;

        // Reset asserted mid-cycle while a claim is being offered.
        bus.claim_ready = 1'b0;
        bus.rand_id     = 8'h5A;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        guard = 0;
        while (!bus.claim_valid && guard < 10) begin
            step();
            guard++;
        end
        chk("rst_mid.reached_send", 32'(bus.claim_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_values("rst_mid");
        step();
        rst_n = 1'b1;
        bus.claim_ready = 1'b1;
        step();
        chk_reset_values("rst_mid_idle");

        // Randomized claims with reserved values, collisions, decoys and stray starts.
        for (int it = 0; it < 20; it++) begin
            raw_ids.delete();
            hit_at.delete();
            for (int a = 0; a < MAX_RETRY; a++) begin
                int n_resv;
                n_resv = $urandom_range(0, 2);
                for (int r = 0; r < n_resv; r++)
                    raw_ids.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF);
                raw_ids.push_back(8'($urandom_range(1, 254)));
                hit_at.push_back(($urandom_range(0, 2) == 0) ? -1
                                 : int'($urandom_range(0, TIMEOUT_CYCLES - 1)));
            end
            decoy_at   = ($urandom_range(0, 1) == 0) ? -1
                         : int'($urandom_range(0, TIMEOUT_CYCLES - 1));
            poke_start = 1'($urandom_range(0, 1));
            run_claim("random", 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
